// File: rtl/reverb_comb_scheduler_if.sv
// Sample-stream and configuration bundle for reverb_comb_scheduler.
// master: the sample source / controller side; slave: the scheduler.
interface reverb_comb_scheduler_if #(
    parameter int NUM_COMBS = 4,
    parameter int SEG_DEPTH = 2048
);
    localparam int CW = $clog2(NUM_COMBS);
    localparam int LW = $clog2(SEG_DEPTH) + 1;

    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [31:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [31:0]   out_data;
    logic                 cfg_we;
    logic [CW-1:0]        cfg_idx;
    logic [LW-1:0]        cfg_len;
    logic                 busy;

    modport master (
        output enable, in_valid, in_data, out_ready, cfg_we, cfg_idx, cfg_len,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  enable, in_valid, in_data, out_ready, cfg_we, cfg_idx, cfg_len,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/reverb_comb_scheduler.sv
// reverb_comb_scheduler: NUM_COMBS feedback comb sections time-shared over one
// single-port delay RAM (NUM_COMBS*SEG_DEPTH x 32, registered read output).
// Each comb owns a SEG_DEPTH-word segment and a circular pointer that wraps at
// its runtime-configurable length. The wet output is the mean of the comb taps.
// Optional build macro: REVERB_COMB_SCHEDULER_MIX_EN -- when defined the reverb
// output is a 50/50 mix of the accepted dry sample and the wet sample.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FLUSH | clearing the delay RAM, one word per cycle, after reset
// ST_IDLE  | waiting for a sample; applies config writes; bypass happens here
// ST_RD    | reading the tap of comb comb_q
// ST_WR    | writing feedback of comb comb_q, accumulating its tap
// ST_DONE  | producing the averaged result, then back to ST_IDLE
module reverb_comb_scheduler #(
    parameter int NUM_COMBS = 4,
    parameter int SEG_DEPTH = 2048,
    parameter int DEF_STEP  = 97
) (
    input  logic                  clk,
    input  logic                  rst,
    reverb_comb_scheduler_if.slave bus
);
    localparam int CW    = $clog2(NUM_COMBS);
    localparam int PW    = $clog2(SEG_DEPTH);
    localparam int LW    = PW + 1;
    localparam int TOTAL = NUM_COMBS * SEG_DEPTH;
    localparam int AW    = $clog2(TOTAL);
    localparam int ACCW  = 32 + CW;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           flush_q, flush_d;
    logic [CW-1:0]           comb_q, comb_d;
    logic [PW-1:0]           ptr_q [NUM_COMBS];
    logic [PW-1:0]           ptr_d [NUM_COMBS];
    logic [LW-1:0]           len_q [NUM_COMBS];
    logic [LW-1:0]           len_d [NUM_COMBS];
    logic                    pend_vld_q, pend_vld_d;
    logic [CW-1:0]           pend_idx_q, pend_idx_d;
    logic [LW-1:0]           pend_len_q, pend_len_d;
    logic signed [31:0]      in_q, in_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [31:0]      out_data_q, out_data_d;

    logic [31:0]             mem [TOTAL];
    logic [31:0]             ram_rdata_q;
    logic                    ram_we;
    logic                    ram_re;
    logic [AW-1:0]           ram_addr;
    logic [31:0]             ram_wdata;

    logic                    in_ready;
    logic                    accept;
    logic [AW-1:0]           seg_addr;
    logic                    ptr_wrap;
    logic signed [31:0]      rd_sample;
    logic signed [31:0]      wr_value;
    logic signed [31:0]      wet;
    logic signed [31:0]      final_sample;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0)
            return LW'(1);
        else if (l > LW'(SEG_DEPTH))
            return LW'(SEG_DEPTH);
        else
            return l;
    endfunction

    function automatic logic [LW-1:0] def_len(input int k);
        return LW'(SEG_DEPTH - k * DEF_STEP);
    endfunction

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = in_ready && bus.in_valid;
    assign seg_addr  = AW'(comb_q) * AW'(SEG_DEPTH) + AW'(ptr_q[comb_q]);
    assign ptr_wrap  = ({1'b0, ptr_q[comb_q]} == (len_q[comb_q] - LW'(1)));
    assign rd_sample = ram_rdata_q;
    assign wr_value  = (in_q >>> 1) + (rd_sample >>> 1) + (rd_sample >>> 2) + (rd_sample >>> 3);
    assign wet       = 32'(acc_q >>> CW);

`ifdef REVERB_COMB_SCHEDULER_MIX_EN
    assign final_sample = (in_q >>> 1) + (wet >>> 1);
`else
    assign final_sample = wet;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != ST_IDLE);

    // Next-state, config handling, RAM control and output register updates.
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        comb_d      = comb_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;
        pend_len_d  = pend_len_q;
        in_d        = in_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = seg_addr;
        ram_wdata   = wr_value;

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        // Pending write lands first so a direct write in the same cycle wins.
        if (state_q == ST_IDLE) begin
            if (pend_vld_q) begin
                len_d[pend_idx_q] = pend_len_q;
                ptr_d[pend_idx_q] = '0;
                pend_vld_d        = 1'b0;
            end
            if (bus.cfg_we) begin
                len_d[bus.cfg_idx] = clamp_len(bus.cfg_len);
                ptr_d[bus.cfg_idx] = '0;
            end
        end else if (bus.cfg_we) begin
            pend_vld_d = 1'b1;
            pend_idx_d = bus.cfg_idx;
            pend_len_d = clamp_len(bus.cfg_len);
        end

        case (state_q)
            ST_FLUSH: begin
                ram_we    = 1'b1;
                ram_addr  = flush_q;
                ram_wdata = '0;
                if (flush_q == AW'(TOTAL - 1))
                    state_d = ST_IDLE;
                else
                    flush_d = flush_q + AW'(1);
            end
            ST_IDLE: begin
                if (accept) begin
                    in_d   = bus.in_data;
                    acc_d  = '0;
                    comb_d = '0;
                    if (bus.enable) begin
                        state_d = ST_RD;
                    end else begin
                        out_data_d  = bus.in_data;
                        out_valid_d = 1'b1;
                        for (int k = 0; k < NUM_COMBS; k++)
                            ptr_d[k] = '0;
                    end
                end
            end
            ST_RD: begin
                ram_re  = 1'b1;
                state_d = ST_WR;
            end
            ST_WR: begin
                ram_we = 1'b1;
                acc_d  = acc_q + ACCW'(rd_sample);
                ptr_d[comb_q] = ptr_wrap ? '0 : ptr_q[comb_q] + PW'(1);
                if (comb_q == CW'(NUM_COMBS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    comb_d  = comb_q + CW'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                out_data_d  = final_sample;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Control and datapath registers; reset drops any in-flight sample and restarts the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_q     <= '0;
            comb_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_len_q  <= '0;
            in_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < NUM_COMBS; k++) begin
                ptr_q[k] <= '0;
                len_q[k] <= def_len(k);
            end
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            comb_q      <= comb_d;
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            pend_len_q  <= pend_len_d;
            in_q        <= in_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
        end
    end

    // Single-port delay RAM with registered read data; no reset on the array.
    always_ff @(posedge clk) begin
        if (ram_we && !rst)
            mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_rdata_q <= mem[ram_addr];
    end
endmodule

// File: tb/tb_reverb_comb_scheduler.sv
// Randomized self-checking bench for reverb_comb_scheduler against a delay-line model.
module tb_reverb_comb_scheduler;
    localparam int NC   = 4;
    localparam int SD   = 16;
    localparam int DS   = 3;
    localparam int CWM  = $clog2(NC);
    localparam int LWM  = $clog2(SD) + 1;
    localparam int SNC  = 2;
    localparam int SSD  = 8;

    logic clk = 1'b0;
    logic m_rst;
    logic s_rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reverb_comb_scheduler_if #(.NUM_COMBS(NC),  .SEG_DEPTH(SD))  m_if ();
    reverb_comb_scheduler_if #(.NUM_COMBS(SNC), .SEG_DEPTH(SSD)) s_if ();

    reverb_comb_scheduler #(.NUM_COMBS(NC), .SEG_DEPTH(SD), .DEF_STEP(DS)) u_main (
        .clk (clk),
        .rst (m_rst),
        .bus (m_if)
    );

    reverb_comb_scheduler #(.NUM_COMBS(SNC), .SEG_DEPTH(SSD), .DEF_STEP(2)) u_small (
        .clk (clk),
        .rst (s_rst),
        .bus (s_if)
    );

    // Behavioural model: one circular delay line per comb.
    logic signed [31:0] mdl_seg [NC][SD];
    int mdl_ptr [NC];
    int mdl_len [NC];
    bit mdl_pend;
    int mdl_pidx;
    int mdl_plen;

    int defer_n = 0;
    int defer_idx [2];
    int defer_len [2];

    function automatic int clampl(input int l);
        if (l < 1)  return 1;
        if (l > SD) return SD;
        return l;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < NC; k++) begin
            for (int j = 0; j < SD; j++) mdl_seg[k][j] = 0;
            mdl_ptr[k] = 0;
            mdl_len[k] = SD - k * DS;
        end
        mdl_pend = 0;
    endtask

    task automatic mdl_apply_pending();
        if (mdl_pend) begin
            mdl_len[mdl_pidx] = mdl_plen;
            mdl_ptr[mdl_pidx] = 0;
            mdl_pend = 0;
        end
    endtask

    task automatic mdl_cfg_idle(input int idx, input int l);
        mdl_apply_pending();
        mdl_len[idx] = clampl(l);
        mdl_ptr[idx] = 0;
    endtask

    task automatic mdl_cfg_busy(input int idx, input int l);
        mdl_pend = 1;
        mdl_pidx = idx;
        mdl_plen = clampl(l);
    endtask

    task automatic mdl_step(input logic signed [31:0] din, input bit en, output logic signed [31:0] res);
        longint acc;
        logic signed [31:0] d;
        logic signed [31:0] wv;
        acc = 0;
        mdl_apply_pending();
        if (!en) begin
            for (int k = 0; k < NC; k++) mdl_ptr[k] = 0;
            res = din;
            return;
        end
        for (int k = 0; k < NC; k++) begin
            d  = mdl_seg[k][mdl_ptr[k]];
            wv = (din >>> 1) + (d >>> 1) + (d >>> 2) + (d >>> 3);
            mdl_seg[k][mdl_ptr[k]] = wv;
            acc = acc + longint'(d);
            mdl_ptr[k] = (mdl_ptr[k] + 1) % mdl_len[k];
        end
        res = 32'(acc >>> CWM);
`ifdef REVERB_COMB_SCHEDULER_MIX_EN
        res = (din >>> 1) + (res >>> 1);
`endif
    endtask

    // One transaction on the main DUT: handshake in, optional deferred cfg, wait, check, drain.
    task automatic do_sample(input logic signed [31:0] din, input bit en, input int hold, input string tag);
        int w;
        int lat;
        int exp_lat;
        logic signed [31:0] exp_v;
        w = 0;
        while (!m_if.in_ready && w < 100) begin @(negedge clk); w++; end
        if (!m_if.in_ready) begin
            total++; bad++;
            $display("FAIL %s_ready got=0 want=1", tag);
            return;
        end
        m_if.in_valid = 1'b1;
        m_if.in_data  = din;
        m_if.enable   = en;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        m_if.in_data  = $urandom;
        m_if.enable   = 1'($urandom_range(0, 1));
        mdl_step(din, en, exp_v);
        total++;
        if (m_if.busy !== en) begin
            bad++;
            $display("FAIL %s_busy got=%0b want=%0b", tag, m_if.busy, en);
        end
        lat = 0;
        for (int i = 0; i < defer_n; i++) begin
            m_if.cfg_we  = 1'b1;
            m_if.cfg_idx = CWM'(defer_idx[i]);
            m_if.cfg_len = LWM'(defer_len[i]);
            mdl_cfg_busy(defer_idx[i], defer_len[i]);
            @(negedge clk);
            lat++;
        end
        m_if.cfg_we = 1'b0;
        defer_n = 0;
        while (!m_if.out_valid && lat < 50) begin @(negedge clk); lat++; end
        exp_lat = en ? 2 * NC + 1 : 0;
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", tag, lat, exp_lat);
        end
        total++;
        if (m_if.out_data !== exp_v) begin
            bad++;
            $display("FAIL %s_data got=%0d want=%0d", tag, m_if.out_data, exp_v);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (m_if.out_valid !== 1'b1 || m_if.out_data !== exp_v || m_if.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s_hold cyc=%0d got v=%0b d=%0d rdy=%0b want v=1 d=%0d rdy=0",
                         tag, i, m_if.out_valid, m_if.out_data, m_if.in_ready, exp_v);
            end
        end
        m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.out_ready = 1'b0;
        total++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_drain got v=%0b rdy=%0b want v=0 rdy=1", tag, m_if.out_valid, m_if.in_ready);
        end
    endtask

    task automatic cfg_idle(input int idx, input int l);
        m_if.cfg_we  = 1'b1;
        m_if.cfg_idx = CWM'(idx);
        m_if.cfg_len = LWM'(l);
        @(negedge clk);
        m_if.cfg_we  = 1'b0;
        mdl_cfg_idle(idx, l);
    endtask

    task automatic count_flush(input string tag);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        while (!m_if.in_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (m_if.out_valid) seen = 1;
        end
        total++;
        if (cnt !== NC * SD) begin
            bad++;
            $display("FAIL %s_flush_cycles got=%0d want=%0d", tag, cnt, NC * SD);
        end
        total++;
        if (seen !== 1'b0 || m_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_flush_end got seen_out=%0b busy=%0b want 0 0", tag, seen, m_if.busy);
        end
    endtask

    task automatic test_reset();
        m_if.enable = 1'b1; m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.out_ready = 1'b0;
        m_if.cfg_we = 1'b0; m_if.cfg_idx = '0;   m_if.cfg_len = '0;
        s_if.enable = 1'b1; s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
        s_if.cfg_we = 1'b0; s_if.cfg_idx = '0;   s_if.cfg_len = '0;
        m_rst = 1'b1;
        s_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (m_if.out_valid !== 1'b0 || m_if.out_data !== 32'sd0 || m_if.in_ready !== 1'b0 || m_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got v=%0b d=%0d rdy=%0b busy=%0b want 0 0 0 1",
                     m_if.out_valid, m_if.out_data, m_if.in_ready, m_if.busy);
        end
        m_rst = 1'b0;
        s_rst = 1'b0;
        mdl_reset();
        count_flush("reset");
    endtask

    task automatic test_impulse();
        int exp_imp [9];
        int w;
        exp_imp = '{0, 0, 0, 250, 250, 0, 218, 0, 218};
        s_if.cfg_we = 1'b1; s_if.cfg_idx = 1'b0; s_if.cfg_len = 4'd4;
        @(negedge clk);
        s_if.cfg_idx = 1'b1; s_if.cfg_len = 4'd3;
        @(negedge clk);
        s_if.cfg_we = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (!s_if.in_ready && w < 50) begin @(negedge clk); w++; end
            s_if.in_valid = 1'b1;
            s_if.in_data  = (i == 0) ? 32'sd1000 : 32'sd0;
            s_if.enable   = 1'b1;
            @(negedge clk);
            s_if.in_valid = 1'b0;
            w = 0;
            while (!s_if.out_valid && w < 50) begin @(negedge clk); w++; end
            total++;
            if (s_if.out_valid !== 1'b1 || s_if.out_data !== exp_imp[i]) begin
                bad++;
                $display("FAIL impulse_out%0d got v=%0b d=%0d want v=1 d=%0d",
                         i, s_if.out_valid, s_if.out_data, exp_imp[i]);
            end
            s_if.out_ready = 1'b1;
            @(negedge clk);
            s_if.out_ready = 1'b0;
        end
    endtask

    task automatic test_latency();
        do_sample(32'sd123456, 1'b1, 0, "lat0");
        do_sample(-32'sd98765, 1'b1, 0, "lat1");
        do_sample(32'sh7fffffff, 1'b1, 0, "lat2");
        do_sample(32'sd0, 1'b1, 0, "lat3");
    endtask

    task automatic test_bypass();
        do_sample(-32'sd12345, 1'b0, 0, "bypass");
        do_sample(32'sd5000, 1'b1, 0, "after_bypass0");
        do_sample(32'sd0, 1'b1, 0, "after_bypass1");
    endtask

    task automatic test_backpressure();
        do_sample(32'sd40000, 1'b1, 20, "bp_reverb");
        do_sample(32'sd77, 1'b0, 5, "bp_bypass");
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] v;
        m_if.out_ready = 1'b1;
        m_if.enable    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            m_if.in_valid = 1'b1;
            m_if.in_data  = v;
            @(negedge clk);
            mdl_step(v, 1'b0, v);
            total++;
            if (m_if.out_valid !== 1'b1 || m_if.out_data !== v || m_if.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d got v=%0b d=%0d rdy=%0b want v=1 d=%0d rdy=1",
                         i, m_if.out_valid, m_if.out_data, m_if.in_ready, v);
            end
        end
        m_if.in_valid = 1'b0;
        @(negedge clk);
        m_if.out_ready = 1'b0;
        total++;
        if (m_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got v=%0b want v=0", m_if.out_valid);
        end
    endtask

    task automatic test_deferred_cfg();
        do_sample(32'sd3000, 1'b1, 0, "dcfg_pre");
        defer_n = 1; defer_idx[0] = 1; defer_len[0] = 0;
        do_sample(32'sd2000, 1'b1, 0, "dcfg_a");
        do_sample(32'sd1000, 1'b1, 0, "dcfg_b");
        do_sample(-32'sd700, 1'b1, 0, "dcfg_c");
        defer_n = 2; defer_idx[0] = 2; defer_len[0] = 31; defer_idx[1] = 3; defer_len[1] = 5;
        do_sample(32'sd9000, 1'b1, 0, "dcfg_d");
        for (int i = 0; i < 6; i++) do_sample(32'sd100 * i, 1'b1, 0, "dcfg_run");
        cfg_idle(0, 2);
        cfg_idle(2, 20);
        for (int i = 0; i < 4; i++) do_sample(-32'sd250 * i, 1'b1, 0, "cfg_idle_run");
    endtask

    task automatic test_mid_reset();
        int w;
        w = 0;
        while (!m_if.in_ready && w < 50) begin @(negedge clk); w++; end
        m_if.in_valid = 1'b1;
        m_if.in_data  = 32'sd777;
        m_if.enable   = 1'b1;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_rst = 1'b1;
        @(negedge clk);
        m_rst = 1'b0;
        total++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b0 || m_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state got v=%0b rdy=%0b busy=%0b want 0 0 1",
                     m_if.out_valid, m_if.in_ready, m_if.busy);
        end
        mdl_reset();
        count_flush("midreset");
        do_sample(32'sd4444, 1'b1, 0, "post_reset0");
        do_sample(32'sd0, 1'b1, 0, "post_reset1");
    endtask

    task automatic test_random();
        logic signed [31:0] din;
        bit en;
        for (int it = 0; it < 50; it++) begin
            if ($urandom_range(0, 4) == 0)
                cfg_idle(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 31)));
            en  = ($urandom_range(0, 3) != 0);
            din = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20000)) - 32'sd10000;
            if (en && $urandom_range(0, 4) == 0) begin
                defer_n      = 1;
                defer_idx[0] = int'($urandom_range(0, NC - 1));
                defer_len[0] = int'($urandom_range(0, 31));
            end
            do_sample(din, en, int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_impulse();
        test_latency();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_deferred_cfg();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
